// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver-side, read-port and status signals of uart_rx_ctrl
interface uart_rx_ctrl_if #(
  parameter int AW = 4
);
  logic          rx_end;
  logic [7:0]    rx_data;
  logic          rx_busy;
  logic          rd_req;
  logic          rd_ack;
  logic [7:0]    rd_data;
  logic          flush;
  logic          ovr_clr;
  logic          udr_clr;
  logic [2:0]    irq_en;
  logic [AW:0]   thresh;
  logic [AW:0]   fifo_cnt;
  logic          empty;
  logic          full;
  logic          ovr;
  logic          udr;
  logic          irq;

  modport master (
    output rx_end, rx_data, rx_busy, rd_req, flush, ovr_clr, udr_clr, irq_en, thresh,
    input  rd_ack, rd_data, fifo_cnt, empty, full, ovr, udr, irq
  );

  modport slave (
    input  rx_end, rx_data, rx_busy, rd_req, flush, ovr_clr, udr_clr, irq_en, thresh,
    output rd_ack, rd_data, fifo_cnt, empty, full, ovr, udr, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive FIFO with request/ack read port, overrun/underrun and interrupt
module uart_rx_ctrl #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 2048
) (
  input logic           clk,
  input logic           reset,
  uart_rx_ctrl_if.slave bus
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0]   TO_MAX   = 16'(TIMEOUT);
  localparam logic [15:0]   TO_ONE   = 16'd1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [15:0]   to_cnt;
  logic          rd_ack_q;
  logic [7:0]    rd_data_q;
  logic          ovr_q;
  logic          udr_q;
  logic          irq_q;

  logic is_empty;
  logic is_full;
  logic pop_ok;
  logic push_ok;
  logic drop;
  logic udr_set;
  logic to_hit;
  logic thr_hit;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_FULL);

  // A push into an empty FIFO is invisible to a same-cycle pop; a pop frees a slot for a push when full.
  assign pop_ok  = bus.rd_req & ~is_empty & ~bus.flush;
  assign push_ok = bus.rx_end & (~is_full | pop_ok) & ~bus.flush;
  assign drop    = bus.rx_end & is_full & ~pop_ok & ~bus.flush;
  assign udr_set = bus.rd_req & is_empty & ~bus.flush;
  assign to_hit  = (to_cnt == TO_MAX) & ~is_empty;
  assign thr_hit = (bus.thresh != '0) & (cnt >= bus.thresh);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      to_cnt    <= '0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= 8'h00;
      ovr_q     <= 1'b0;
      udr_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rd_ack_q <= bus.rd_req;

      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        if (bus.rd_req) rd_data_q <= 8'h00;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop_ok})
          2'b10:   cnt <= cnt + CNT_ONE;
          2'b01:   cnt <= cnt - CNT_ONE;
          default: cnt <= cnt;
        endcase
        if (bus.rd_req) rd_data_q <= pop_ok ? mem[rd_ptr] : 8'h00;
      end

      if (drop)             ovr_q <= 1'b1;
      else if (bus.ovr_clr) ovr_q <= 1'b0;

      if (udr_set)          udr_q <= 1'b1;
      else if (bus.udr_clr) udr_q <= 1'b0;

      if (push_ok || pop_ok || is_empty || bus.rx_busy || bus.flush)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + TO_ONE;

      irq_q <= (bus.irq_en[0] & thr_hit) |
               (bus.irq_en[1] & to_hit)  |
               (bus.irq_en[2] & ovr_q);
    end
  end

  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.fifo_cnt = cnt;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.ovr      = ovr_q;
  assign bus.udr      = udr_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] q[$];

  uart_rx_ctrl_if #(.AW(AW)) bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_end  = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_end  = 1'b0;
  endtask

  task automatic read(input string tag, input logic [7:0] exp);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check({tag, "_ack"}, 32'(bus.rd_ack), 32'd1);
    check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic pair(input string tag, input logic [7:0] b);
    logic [7:0] exp;
    exp = q.pop_front();
    q.push_back(b);
    bus.rx_end  = 1'b1;
    bus.rx_data = b;
    bus.rd_req  = 1'b1;
    tick();
    bus.rx_end  = 1'b0;
    bus.rd_req  = 1'b0;
    check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    bus.rx_end  = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_busy = 1'b0;
    bus.rd_req  = 1'b0;
    bus.flush   = 1'b0;
    bus.ovr_clr = 1'b0;
    bus.udr_clr = 1'b0;
    bus.irq_en  = 3'b000;
    bus.thresh  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   32'(bus.rd_ack),   32'd0);
    check("rst_data",  32'(bus.rd_data),  32'h00);
    check("rst_cnt",   32'(bus.fifo_cnt), 32'd0);
    check("rst_empty", 32'(bus.empty),    32'd1);
    check("rst_full",  32'(bus.full),     32'd0);
    check("rst_ovr",   32'(bus.ovr),      32'd0);
    check("rst_udr",   32'(bus.udr),      32'd0);
    check("rst_irq",   32'(bus.irq),      32'd0);
    #2 reset = 1'b1;
    tick();

    // basic ordering
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("b_cnt3", 32'(bus.fifo_cnt), 32'd3);
    check("b_nempty", 32'(bus.empty), 32'd0);
    read("b_r0", 8'h41);
    check("b_cnt2", 32'(bus.fifo_cnt), 32'd2);
    read("b_r1", 8'h42);
    read("b_r2", 8'h43);
    check("b_cnt0", 32'(bus.fifo_cnt), 32'd0);
    check("b_empty", 32'(bus.empty), 32'd1);
    tick();
    check("b_ack_drop", 32'(bus.rd_ack), 32'd0);

    // overrun
    bus.irq_en = 3'b100;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("o_full", 32'(bus.full), 32'd1);
    check("o_ovr0", 32'(bus.ovr), 32'd0);
    push(8'hFF);
    check("o_ovr1", 32'(bus.ovr), 32'd1);
    check("o_cnt16", 32'(bus.fifo_cnt), 32'd16);
    tick();
    check("o_irq", 32'(bus.irq), 32'd1);
    for (int i = 0; i < 16; i++) read($sformatf("o_r%0d", i), 8'(i));
    check("o_empty", 32'(bus.empty), 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("o_clr", 32'(bus.ovr), 32'd0);
    tick();
    check("o_irq_off", 32'(bus.irq), 32'd0);
    bus.irq_en = 3'b000;

    // underrun and set-beats-clear
    read("u_r", 8'h00);
    check("u_udr", 32'(bus.udr), 32'd1);
    bus.ovr_clr = 1'b1;
    bus.udr_clr = 1'b1;
    bus.rd_req  = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    bus.udr_clr = 1'b0;
    bus.rd_req  = 1'b0;
    check("u_sticky", 32'(bus.udr), 32'd1);
    bus.udr_clr = 1'b1;
    tick();
    bus.udr_clr = 1'b0;
    check("u_clr", 32'(bus.udr), 32'd0);

    // full with simultaneous push/pop, then wrap
    q.delete();
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h80 + i));
      q.push_back(8'(8'h80 + i));
    end
    pair("f_pp", 8'hAA);
    check("f_cnt16", 32'(bus.fifo_cnt), 32'd16);
    check("f_ovr", 32'(bus.ovr), 32'd0);
    for (int i = 0; i < 40; i++) pair($sformatf("w%0d", i), 8'(i * 7 + 3));
    check("w_cnt16", 32'(bus.fifo_cnt), 32'd16);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("w_flush", 32'(bus.fifo_cnt), 32'd0);

    // idle timeout
    bus.irq_en = 3'b010;
    push(8'h55);
    repeat (20) tick();
    check("t_irq20", 32'(bus.irq), 32'd0);
    tick();
    check("t_irq21", 32'(bus.irq), 32'd1);
    read("t_rd", 8'h55);
    check("t_irq_hold", 32'(bus.irq), 32'd1);
    tick();
    check("t_irq_drop", 32'(bus.irq), 32'd0);
    bus.rx_busy = 1'b1;
    push(8'h66);
    repeat (40) tick();
    check("t_busy", 32'(bus.irq), 32'd0);
    bus.rx_busy = 1'b0;
    bus.flush   = 1'b1;
    tick();
    bus.flush   = 1'b0;

    // threshold and flush with concurrent push
    bus.irq_en = 3'b001;
    bus.thresh = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(i));
    tick();
    check("h_irq3", 32'(bus.irq), 32'd0);
    push(8'h03);
    check("h_irq_n", 32'(bus.irq), 32'd0);
    tick();
    check("h_irq_n1", 32'(bus.irq), 32'd1);
    bus.flush   = 1'b1;
    bus.rx_end  = 1'b1;
    bus.rx_data = 8'h77;
    tick();
    bus.flush   = 1'b0;
    bus.rx_end  = 1'b0;
    check("h_fl_cnt", 32'(bus.fifo_cnt), 32'd0);
    check("h_fl_ovr", 32'(bus.ovr), 32'd0);
    tick();
    check("h_fl_irq", 32'(bus.irq), 32'd0);

    // asynchronous reset mid-stream
    read("r_udr", 8'h00);
    bus.thresh = 5'd1;
    push(8'h11);
    push(8'h22);
    bus.rd_req = 1'b1;
    tick();
    check("r_pre_irq", 32'(bus.irq), 32'd1);
    check("r_pre_ack", 32'(bus.rd_ack), 32'd1);
    check("r_pre_udr", 32'(bus.udr), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("r_ack",   32'(bus.rd_ack),   32'd0);
    check("r_data",  32'(bus.rd_data),  32'h00);
    check("r_cnt",   32'(bus.fifo_cnt), 32'd0);
    check("r_empty", 32'(bus.empty),    32'd1);
    check("r_udr",   32'(bus.udr),      32'd0);
    check("r_irq",   32'(bus.irq),      32'd0);
    bus.rd_req = 1'b0;
    #3 reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. Captures each completed byte from the receiver into a DEPTH-entry FIFO. Serves bytes to the bus-side register block over a request/acknowledge read port. Tracks overrun and underrun, and raises a maskable interrupt on a fill threshold or on an idle-line character timeout. Sits between the UART receiver and the UART bus register decoder, in the same clock domain as both.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- AW, 4, log2(DEPTH).
- TIMEOUT, 2048, idle clock cycles before the timeout interrupt fires; range 1 .. 2^16-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_end  in  1  one-cycle pulse from the receiver: a valid byte is on rx_data.
- rx_data  in  8  received byte, valid while rx_end=1.
- rx_busy  in  1  receiver is mid-character.
- rd_req  in  1  one-cycle read request from the bus side.
- rd_ack  out  1  one-cycle acknowledge, exactly one cycle after rd_req; reset 0.
- rd_data  out  8  popped byte, valid while rd_ack=1; reset 8'h00.
- flush  in  1  synchronous FIFO clear.
- ovr_clr  in  1  clears the overrun flag.
- udr_clr  in  1  clears the underrun flag.
- irq_en  in  3  interrupt enables: [0] threshold, [1] timeout, [2] overrun.
- thresh  in  AW+1  fill threshold; 0 disables the threshold interrupt.
- fifo_cnt  out  AW+1  current occupancy, 0..DEPTH; reset 0.
- empty  out  1  fifo_cnt==0; reset 1.
- full  out  1  fifo_cnt==DEPTH; reset 0.
- ovr  out  1  sticky overrun flag; reset 0.
- udr  out  1  sticky underrun flag; reset 0.
- irq  out  1  registered interrupt; reset 0.

## Operation
- Storage is a DEPTH×8 register array with wr_ptr and rd_ptr, each AW bits wide and wrapping modulo DEPTH. cnt is AW+1 bits.
- Push: rx_end=1 and (not full, or pop in the same cycle) → mem[wr_ptr]<=rx_data and wr_ptr++.
- Push while full with no pop in the same cycle → byte dropped, ovr<=1, FIFO unchanged.
- Pop: rd_req=1 and not empty → rd_data<=mem[rd_ptr], rd_ptr++.
- Read while empty → rd_data<=8'h00, udr<=1, pointers unchanged.
- rd_ack<=rd_req in every case.
- Simultaneous push and pop: both happen and cnt is unchanged. A push into an empty FIFO is not visible to a pop requested in the same cycle; that pop is an underrun.
- Flush has the highest priority: pointers and cnt go to 0, the timeout counter goes to 0, and any push or pop in that cycle is discarded. ovr and udr are not affected. rd_ack still follows rd_req, with rd_data=8'h00 and udr unchanged.
- Sticky flags: when a set and its clear (ovr_clr / udr_clr) occur in the same cycle, the set wins.
- Timeout counter to_cnt (16 bits) clears to 0 on any of: push, pop, empty, rx_busy=1, flush.
- Otherwise to_cnt increments and saturates at TIMEOUT.
- to_hit = (to_cnt==TIMEOUT) and not empty.
- irq <= (irq_en[0] & thresh!=0 & cnt>=thresh) | (irq_en[1] & to_hit) | (irq_en[2] & ovr). All terms use the current register values.
- Reset mid-operation: every register returns to its reset value immediately. Stored data is lost. The array contents are don't-care.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Push on edge N → fifo_cnt, empty and full update at edge N.
- irq reflects the new cnt at edge N+1.
- rd_req high in cycle N → rd_ack=1 and rd_data valid in cycle N+1 only.
- Back-to-back rd_req is allowed every cycle and gives one byte per cycle.
- Overrun: ovr is set at the edge that samples the dropped rx_end.
- Timeout: the last push/pop happens at edge E with rx_busy=0 throughout. to_cnt reaches TIMEOUT at edge E+TIMEOUT, and irq rises at edge E+TIMEOUT+1 (if irq_en[1]=1).
- irq deasserts one cycle after the causing condition clears.

## Test plan
- Reset, then 3 rx_end pulses carrying 0x41, 0x42, 0x43, then 3 single-cycle rd_req → rd_ack each following cycle with rd_data 0x41, 0x42, 0x43 in order; fifo_cnt goes 3→0; empty=1 at the end.
- Fill with 16 bytes (0x00..0x0F), then a 17th rx_end with 0xFF → full=1, ovr=1, the byte is dropped. With irq_en=3'b100, irq=1. Reading all 16 returns 0x00..0x0F. ovr_clr → ovr=0 and irq=0 one cycle later.
- rd_req with the FIFO empty → rd_ack=1, rd_data=0x00, udr=1. Pulse ovr_clr and udr_clr together while a new underrun occurs → udr stays 1.
- FIFO full; rx_end and rd_req in the same cycle → oldest byte returned, new byte stored, fifo_cnt stays 16, ovr stays 0. Wrap: 40 push/pop pairs preserve order.
- TIMEOUT=20, irq_en=3'b010, one byte pushed, rx_busy=0 → irq rises exactly 21 cycles after the push edge. A rd_req drops irq the following cycle. With rx_busy held at 1, irq never rises.
- thresh=4, irq_en=3'b001: the 4th push raises irq next cycle. Flush during a concurrent push → fifo_cnt=0, irq low next cycle, ovr unchanged. Assert reset mid-stream → all outputs return to reset values asynchronously.
